// File: rtl/freq_gen.sv
// -----------------------------------------------------------------------------
// freq_gen - programmable NCO frequency generator (test_clk domain)
//
// A phase accumulator adds active_inc every RUN cycle. Its MSB is the square
// wave (out_clk), and its carry marks one output period (out_strb). The output
// frequency is f_test_clk * inc / 2^ACC_WIDTH. The block runs in two modes:
// continuous mode (cfg_burst = 0), or a burst of cfg_burst periods.
//
// Increment updates go through a shadow register. They only reach the
// accumulator at a period boundary, so a running waveform never produces a
// runt period.
//
// Optional feature (macro FREQ_GEN_PHASE_RESET_EN):
//   defined   : every accepted start clears the accumulator (phase 0 start)
//   undefined : the accumulator keeps its phase across runs; only nrst clears it
//
// Ports:
//   test_clk   in   clock
//   nrst       in   synchronous active-low reset
//   cfg_inc    in   [ACC_WIDTH] phase increment
//   cfg_burst  in   [CNT_WIDTH] periods per burst, 0 = continuous
//   cfg_load   in   strobe: capture cfg_inc into the shadow register
//   start      in   strobe: begin generation
//   stop       in   strobe: abort generation
//   out_clk    out  square wave (accumulator MSB), registered
//   out_strb   out  one-cycle pulse per accumulator overflow
//   busy       out  high while running
//   done       out  one-cycle pulse on burst completion
//   periods    out  [CNT_WIDTH] periods generated since last start
//   err        out  one-cycle pulse when start is rejected (zero increment)
// -----------------------------------------------------------------------------
module freq_gen #(
    parameter int ACC_WIDTH = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 test_clk,
    input  logic                 nrst,
    input  logic [ACC_WIDTH-1:0] cfg_inc,
    input  logic [CNT_WIDTH-1:0] cfg_burst,
    input  logic                 cfg_load,
    input  logic                 start,
    input  logic                 stop,
    output logic                 out_clk,
    output logic                 out_strb,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] periods,
    output logic                 err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_r;
    logic [ACC_WIDTH-1:0] acc_r;
    logic [ACC_WIDTH-1:0] shadow_inc_r;
    logic [ACC_WIDTH-1:0] active_inc_r;
    logic [CNT_WIDTH-1:0] burst_target_r;

    logic [ACC_WIDTH:0]   sum_s;
    logic                 carry_s;
    logic [CNT_WIDTH-1:0] periods_inc_s;
    logic                 final_s;

    // Next accumulator value, overflow carry and burst-completion detect
    always_comb begin
        sum_s         = {1'b0, acc_r} + {1'b0, active_inc_r};
        carry_s       = sum_s[ACC_WIDTH];
        periods_inc_s = periods + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        final_s       = carry_s && (burst_target_r != {CNT_WIDTH{1'b0}})
                        && (periods_inc_s == burst_target_r);
    end

    // Control FSM, accumulator datapath and registered outputs
    always_ff @(posedge test_clk) begin
        if (!nrst) begin
            state_r        <= ST_IDLE;
            acc_r          <= {ACC_WIDTH{1'b0}};
            shadow_inc_r   <= {ACC_WIDTH{1'b0}};
            active_inc_r   <= {ACC_WIDTH{1'b0}};
            burst_target_r <= {CNT_WIDTH{1'b0}};
            periods        <= {CNT_WIDTH{1'b0}};
            out_clk        <= 1'b0;
            out_strb       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            if (cfg_load) begin
                shadow_inc_r <= cfg_inc;
            end
            case (state_r)
                ST_IDLE: begin
                    out_clk  <= 1'b0;
                    out_strb <= 1'b0;
                    done     <= 1'b0;
                    if (cfg_load) begin
                        active_inc_r <= cfg_inc;
                    end
                    // stop wins over start; a zero increment would never overflow
                    if (start && !stop) begin
                        if (active_inc_r == {ACC_WIDTH{1'b0}}) begin
                            err  <= 1'b1;
                            busy <= 1'b0;
                        end else begin
                            err            <= 1'b0;
                            busy           <= 1'b1;
                            state_r        <= ST_RUN;
                            burst_target_r <= cfg_burst;
                            periods        <= {CNT_WIDTH{1'b0}};
`ifdef FREQ_GEN_PHASE_RESET_EN
                            acc_r          <= {ACC_WIDTH{1'b0}};
`endif
                        end
                    end else begin
                        err  <= 1'b0;
                        busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    err <= 1'b0;
                    // A stop coinciding with the final burst overflow still completes the burst
                    if (stop && !final_s) begin
                        state_r  <= ST_IDLE;
                        busy     <= 1'b0;
                        out_clk  <= 1'b0;
                        out_strb <= 1'b0;
                        done     <= 1'b0;
                    end else begin
                        acc_r    <= sum_s[ACC_WIDTH-1:0];
                        out_clk  <= sum_s[ACC_WIDTH-1];
                        out_strb <= carry_s;
                        if (carry_s) begin
                            periods <= periods_inc_s;
                            // Period boundary: adopt the pending increment; a load
                            // in this very cycle bypasses the shadow register
                            active_inc_r <= cfg_load ? cfg_inc : shadow_inc_r;
                        end
                        if (final_s) begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            busy    <= 1'b1;
                            done    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    busy     <= 1'b0;
                    out_clk  <= 1'b0;
                    out_strb <= 1'b0;
                    done     <= 1'b0;
                    err      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_gen.sv
// -----------------------------------------------------------------------------
// tb_freq_gen - self-checking bench for freq_gen.
// A behavioural reference tracks the phase as a plain integer. It compares
// phase + increment against 2^32 to find each period boundary, and it predicts
// every output in every cycle. Directed scenarios and a randomized run drive
// the design.
// -----------------------------------------------------------------------------
module tb_freq_gen;

    localparam int AW = 32;
    localparam int CW = 32;
    localparam longint FULL = 64'd4294967296;

    logic          test_clk = 1'b0;
    logic          nrst;
    logic [AW-1:0] cfg_inc;
    logic [CW-1:0] cfg_burst;
    logic          cfg_load, start, stop;
    logic          out_clk, out_strb, busy, done, err;
    logic [CW-1:0] periods;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    freq_gen #(.ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .test_clk (test_clk),
        .nrst     (nrst),
        .cfg_inc  (cfg_inc),
        .cfg_burst(cfg_burst),
        .cfg_load (cfg_load),
        .start    (start),
        .stop     (stop),
        .out_clk  (out_clk),
        .out_strb (out_strb),
        .busy     (busy),
        .done     (done),
        .periods  (periods),
        .err      (err)
    );

    always #5 test_clk = ~test_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    longint m_phase, m_shadow, m_active, m_target, m_periods;
    bit     m_run, m_clk, m_strb, m_busy, m_done, m_err;

    always @(posedge test_clk) begin : ref_model
        longint nxt;
        bit     ovf, fin, run_n;
        if (!nrst) begin
            m_phase <= 0; m_shadow <= 0; m_active <= 0; m_target <= 0; m_periods <= 0;
            m_run <= 0; m_clk <= 0; m_strb <= 0; m_busy <= 0; m_done <= 0; m_err <= 0;
        end else begin
            run_n = m_run;
            m_err  <= 1'b0;
            m_done <= 1'b0;
            if (cfg_load) m_shadow <= longint'(cfg_inc);
            if (!m_run) begin
                m_clk  <= 1'b0;
                m_strb <= 1'b0;
                if (cfg_load) m_active <= longint'(cfg_inc);
                if (start && !stop) begin
                    if (m_active == 0) m_err <= 1'b1;
                    else begin
                        run_n     = 1'b1;
                        m_target  <= longint'(cfg_burst);
                        m_periods <= 0;
`ifdef FREQ_GEN_PHASE_RESET_EN
                        m_phase   <= 0;
`endif
                    end
                end
            end else begin
                nxt = m_phase + m_active;
                ovf = (nxt >= FULL);
                if (ovf) nxt = nxt - FULL;
                fin = ovf && (m_target != 0) && (((m_periods + 1) % FULL) == m_target);
                if (stop && !fin) begin
                    run_n  = 1'b0;
                    m_clk  <= 1'b0;
                    m_strb <= 1'b0;
                end else begin
                    m_phase <= nxt;
                    m_clk   <= (nxt >= FULL / 2);
                    m_strb  <= ovf;
                    if (ovf) begin
                        m_periods <= (m_periods + 1) % FULL;
                        m_active  <= cfg_load ? longint'(cfg_inc) : m_shadow;
                    end
                    if (fin) begin
                        run_n  = 1'b0;
                        m_done <= 1'b1;
                    end
                end
            end
            m_run  <= run_n;
            m_busy <= run_n;
        end
    end

    // Compare every output against the reference model away from the active edge
    always @(negedge test_clk) begin
        if (check_en) begin
            check("out_clk",  64'(out_clk),  64'(m_clk));
            check("out_strb", 64'(out_strb), 64'(m_strb));
            check("busy",     64'(busy),     64'(m_busy));
            check("done",     64'(done),     64'(m_done));
            check("err",      64'(err),      64'(m_err));
            check("periods",  64'(periods),  64'(m_periods));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge test_clk);
    endtask

    task automatic load_inc(input logic [AW-1:0] v);
        cfg_inc = v; cfg_load = 1'b1; cyc(1); cfg_load = 1'b0;
    endtask

    task automatic do_start(input logic [CW-1:0] b);
        cfg_burst = b; start = 1'b1; cyc(1); start = 1'b0;
    endtask

    initial begin : stim
        int strb_cnt, done_cnt, last, gap_ok;
        nrst = 1'b0; start = 1'b1; stop = 1'b0; cfg_load = 1'b0;
        cfg_inc = 32'h0; cfg_burst = 32'h0;
        @(posedge test_clk);
        #1 check_en = 1'b1;
        cyc(3);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err",  64'(err),  64'd0);
        nrst = 1'b1; start = 1'b0;
        cyc(1);

        // Continuous at quarter rate: strobe every 4 cycles from phase 0
        load_inc(32'h4000_0000);
        do_start(32'd0);
        strb_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            if (out_strb) strb_cnt++;
            check("quarter_strb", 64'(out_strb), 64'((i % 4) == 0));
        end
        check("cont_strobes", 64'(strb_cnt), 64'd3);
        check("cont_periods", 64'(periods), 64'd3);
        stop = 1'b1; cyc(1); stop = 1'b0;
        cyc(2);

        // Burst of 3
        do_start(32'd3);
        strb_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_strb) strb_cnt++;
            if (done) done_cnt++;
            cyc(1);
        end
        check("burst_strobes", 64'(strb_cnt), 64'd3);
        check("burst_done",    64'(done_cnt), 64'd1);
        check("burst_periods", 64'(periods),  64'd3);
        check("burst_busy",    64'(busy),     64'd0);

        // Mid-period increment change: spacing only ever 4 or 8
        do_start(32'd0);
        cyc(5);
        load_inc(32'h2000_0000);
        last = -1; gap_ok = 1;
        for (int i = 0; i < 40; i++) begin
            if (out_strb) begin
                if (last >= 0 && (i - last) != 4 && (i - last) != 8) gap_ok = 0;
                last = i;
            end
            cyc(1);
        end
        check("spacing_ok", 64'(gap_ok), 64'd1);
        stop = 1'b1; cyc(1); stop = 1'b0;

        // Zero increment rejected with err; start+stop together stays idle
        load_inc(32'h0);
        do_start(32'd0);
        check("zero_err",  64'(err),  64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        load_inc(32'h4000_0000);
        start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
        check("ss_busy", 64'(busy), 64'd0);

        // Stop after 10 cycles, then restart (phase continuity per build)
        do_start(32'd0);
        cyc(9);
        stop = 1'b1; cyc(1); stop = 1'b0;
        check("stop_clk",  64'(out_clk),  64'd0);
        check("stop_done", 64'(done),     64'd0);
        cyc(3);
        do_start(32'd0);
        cyc(8);
        stop = 1'b1; cyc(1); stop = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            nrst      = ($urandom_range(0, 299) != 0);
            cfg_load  = ($urandom_range(0, 7) == 0);
            cfg_inc   = $urandom() >> $urandom_range(0, 5);
            cfg_burst = $urandom_range(0, 5);
            start     = ($urandom_range(0, 5) == 0);
            stop      = ($urandom_range(0, 24) == 0);
            cyc(1);
        end
        nrst = 1'b1; cfg_load = 1'b0; start = 1'b0; stop = 1'b0;
        cyc(2);
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/freq_gen.md
Name: freq_gen

Overview:
- Programmable frequency generator (NCO, phase accumulator) in the test_clk domain.
- Produces a square wave and a per-period strobe at f_out = f_test_clk * inc / 2^ACC_WIDTH.
- Transmit-side counterpart of the frequency meter: its out_clk / out_strb drive the meter's test signal and enable for calibration and self-test.
- Supports continuous and burst (N periods) modes and glitch-free increment updates while running.

Parameters:
ACC_WIDTH, 32, phase accumulator width; sets frequency resolution f_test_clk / 2^ACC_WIDTH
CNT_WIDTH, 32, burst and period counter width

Ports:
test_clk  input  1  clock
nrst  input  1  reset, synchronous, active-low
cfg_inc  input  ACC_WIDTH  phase increment
cfg_burst  input  CNT_WIDTH  periods to generate; 0 = continuous
cfg_load  input  1  strobe: capture cfg_inc into the shadow register
start  input  1  strobe: begin generation
stop  input  1  strobe: abort generation
out_clk  output  1  square wave = accumulator MSB, registered
out_strb  output  1  one-cycle pulse per accumulator overflow (one output period)
busy  output  1  high in RUN
done  output  1  one-cycle pulse on burst completion
periods  output  CNT_WIDTH  periods generated since last start
err  output  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (nrst=0 at posedge test_clk):
  - state=IDLE; acc, shadow_inc, active_inc, burst_cnt and periods = 0.
  - All outputs 0.
- States: IDLE, RUN.
- cfg_load:
  - shadow_inc <= cfg_inc in any state.
  - In IDLE, active_inc <= cfg_inc in the same cycle.
  - In RUN, active_inc <= shadow_inc only on an overflow cycle. Frequency changes at a period boundary; no runt period.
- IDLE -> RUN on start=1:
  - Requires stop=0 and active_inc != 0. If active_inc == 0, stay IDLE and pulse err for 1 cycle.
  - On transition: burst_target <= cfg_burst, periods <= 0, acc handled per the optional feature.
- RUN, each cycle:
  - {carry, acc} <= acc + active_inc, using ACC_WIDTH+1-bit arithmetic with the result wrapped to ACC_WIDTH.
  - out_clk <= new acc MSB.
  - out_strb <= carry.
  - If carry: periods <= periods + 1, wrapping at 2^CNT_WIDTH.
- Burst completion: when burst_target != 0 and carry makes periods reach burst_target:
  - done=1 in the same cycle as that final out_strb; state <= IDLE.
  - Next cycle: out_clk=0, busy=0.
- Continuous mode (burst_target=0): runs until stop; periods wraps silently.
- RUN -> IDLE on stop=1:
  - Immediate at that edge; no done pulse.
  - out_clk and out_strb are 0 from the next cycle.
  - acc and periods are held.
- Simultaneous events:
  - start in RUN is ignored.
  - start and stop in the same cycle: stop wins; remain or go to IDLE.
  - stop on the final-burst overflow cycle: done is still pulsed; state goes to IDLE.
  - cfg_load on an overflow cycle in RUN: active_inc takes the newly loaded cfg_inc directly (bypass).
- In IDLE: out_clk=0, out_strb=0, busy=0; acc is frozen.
- Latency: start sampled at edge E0. First acc update at E1. The first out_strb is visible after edge E(k), where k = ceil(2^ACC_WIDTH / inc) with the accumulator starting from 0.
- Reset mid-RUN: next cycle is full reset state; no done pulse.

Optional Feature:
- Macro FREQ_GEN_PHASE_RESET_EN.
- Defined: acc <= 0 on every accepted start, so every run begins at phase 0 and the first out_strb is deterministic.
- Undefined: acc keeps its value from the previous run (phase-continuous restart). Only nrst clears acc.

Test Plan:
- nrst=0 for 3 cycles with start=1 -> all outputs 0, busy=0, no err.
- Phase reset enabled; cfg_load inc=0x4000_0000, cfg_burst=0, start -> out_strb every 4 cycles, first after 4th edge; out_clk 2 high / 2 low; periods counts 1,2,3...
- inc=0x4000_0000, cfg_burst=3, start -> exactly 3 out_strb; done coincides with the 3rd; busy=0 next cycle; periods=3.
- Running at inc=0x4000_0000; cfg_load 0x2000_0000 mid-period -> current 4-cycle period completes; subsequent strobes every 8 cycles; no strobe spacing other than 4 or 8.
- active_inc=0, start -> err 1-cycle pulse, busy stays 0; also start+stop in the same cycle with valid inc -> stays IDLE.
- Continuous run; stop after 10 cycles -> out_clk and out_strb 0 next cycle, no done, periods=2 held; with the macro undefined, restart shows acc continuing from the held phase (first strobe earlier than 4 cycles).
